// File: rtl/sync_rr_collector.sv
// Round-robin collector: merges NUM_CH task streams, extracts one argument field
// from each accepted task and buffers it in a DEPTH-entry FIFO with a registered head.
module sync_rr_collector #(
  parameter int NUM_CH     = 4,
  parameter int TASK_WIDTH = 128,
  parameter int ARG_LSB    = 64,
  parameter int ARG_WIDTH  = 64,
  parameter int DEPTH      = 4
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic [NUM_CH*TASK_WIDTH-1:0]  taskIn_TDATA,
  input  logic [NUM_CH-1:0]             taskIn_TVALID,
  output logic [NUM_CH-1:0]             taskIn_TREADY,
  output logic [ARG_WIDTH-1:0]          argOut_TDATA,
  output logic                          argOut_TVALID,
  input  logic                          argOut_TREADY,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic [31:0]                   arg_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [ARG_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]        wrPtr, rdPtr;
  logic [RW-1:0]        rrPtr, grant, rrNext;
  logic                 anyValid, full, push, pop;
  logic [ARG_WIDTH-1:0] pushArg;

  function automatic int wrapIdx(input int v);
    return (v >= NUM_CH) ? v - NUM_CH : v;
  endfunction

  // Walk from the farthest candidate back to rrPtr so the closest valid channel wins.
  always_comb begin
    grant    = rrPtr;
    anyValid = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (taskIn_TVALID[wrapIdx(int'(rrPtr) + k)]) begin
        grant    = RW'(wrapIdx(int'(rrPtr) + k));
        anyValid = 1'b1;
      end
    end
  end

  assign full          = (fifo_count == CW'(DEPTH));
  assign push          = anyValid && !full && !ap_rst;
  assign pop           = argOut_TVALID && argOut_TREADY;
  assign argOut_TVALID = (fifo_count != '0);
  assign pushArg       = taskIn_TDATA[int'(grant)*TASK_WIDTH + ARG_LSB +: ARG_WIDTH];
  assign rrNext        = (grant == RW'(NUM_CH - 1)) ? '0 : grant + 1'b1;

  always_comb begin
    taskIn_TREADY = '0;
    if (push) taskIn_TREADY[grant] = 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (push) mem[wrPtr] <= pushArg;
  end

  // The head register mirrors mem[rdPtr] while non-empty and keeps the last value when drained.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wrPtr        <= '0;
      rdPtr        <= '0;
      rrPtr        <= '0;
      fifo_count   <= '0;
      arg_count    <= '0;
      argOut_TDATA <= '0;
    end else begin
      if (push) begin
        wrPtr <= wrPtr + PW'(1);
        rrPtr <= rrNext;
      end
      if (pop) begin
        rdPtr     <= rdPtr + PW'(1);
        arg_count <= arg_count + 32'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && ((fifo_count == '0) || (pop && fifo_count == CW'(1))))
        argOut_TDATA <= pushArg;
      else if (pop && fifo_count > CW'(1))
        argOut_TDATA <= mem[rdPtr + PW'(1)];
    end
  end

endmodule

// File: tb/tb_sync_rr_collector.sv
// Directed and randomized checks of sync_rr_collector against a queue-based reference model,
// plus a narrow-argument, deep-FIFO variant instance.
module tb_sync_rr_collector;

  localparam int NUM_CH = 4;
  localparam int TW     = 128;
  localparam int ALSB   = 64;
  localparam int AW     = 64;
  localparam int DEPTH  = 4;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst;
  logic [NUM_CH*TW-1:0]    taskIn_TDATA;
  logic [NUM_CH-1:0]       taskIn_TVALID;
  logic [NUM_CH-1:0]       taskIn_TREADY;
  logic [AW-1:0]           argOut_TDATA;
  logic                    argOut_TVALID;
  logic                    argOut_TREADY;
  logic [2:0]              fifo_count;
  logic [31:0]             arg_count;

  logic [191:0]            vData;
  logic [1:0]              vValid, vReady;
  logic [31:0]             vArg;
  logic                    vArgValid, vArgReady;
  logic [3:0]              vCount;
  logic [31:0]             vArgCnt;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] mq[$];
  int            mRr;
  int unsigned   mArgCnt;
  logic [AW-1:0] mLast;
  logic [31:0]   vq[$];

  always #5 ap_clk = ~ap_clk;

  sync_rr_collector #(.NUM_CH(NUM_CH), .TASK_WIDTH(TW), .ARG_LSB(ALSB), .ARG_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .taskIn_TDATA(taskIn_TDATA), .taskIn_TVALID(taskIn_TVALID), .taskIn_TREADY(taskIn_TREADY),
    .argOut_TDATA(argOut_TDATA), .argOut_TVALID(argOut_TVALID), .argOut_TREADY(argOut_TREADY),
    .fifo_count(fifo_count), .arg_count(arg_count)
  );

  sync_rr_collector #(.NUM_CH(2), .TASK_WIDTH(96), .ARG_LSB(0), .ARG_WIDTH(32), .DEPTH(8)) dutVar (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .taskIn_TDATA(vData), .taskIn_TVALID(vValid), .taskIn_TREADY(vReady),
    .argOut_TDATA(vArg), .argOut_TVALID(vArgValid), .argOut_TREADY(vArgReady),
    .fifo_count(vCount), .arg_count(vArgCnt)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pickGrant(input logic [NUM_CH-1:0] valid);
    if (mq.size() >= DEPTH) return -1;
    for (int k = 0; k < NUM_CH; k++)
      if (valid[(mRr + k) % NUM_CH]) return (mRr + k) % NUM_CH;
    return -1;
  endfunction

  function automatic void modelReset();
    mq.delete();
    mRr     = 0;
    mArgCnt = 0;
    mLast   = '0;
  endfunction

  // One cycle: drive inputs, check everything against the model, then advance the model.
  task automatic applyStimulus(input logic [NUM_CH-1:0] valid, input logic outReady);
    int                g;
    logic [NUM_CH-1:0] expReady;
    taskIn_TVALID = valid;
    argOut_TREADY = outReady;
    #1;
    g = pickGrant(valid);
    expReady = '0;
    if (g >= 0) expReady[g] = 1'b1;
    checkOutput("tready", taskIn_TREADY, expReady);
    checkOutput("tvalid", argOut_TVALID, mq.size() > 0);
    checkOutput("tdata", argOut_TDATA, (mq.size() > 0) ? mq[0] : mLast);
    checkOutput("fifo_count", fifo_count, mq.size());
    checkOutput("arg_count", arg_count, mArgCnt);
    @(posedge ap_clk);
    if (mq.size() > 0 && outReady) begin
      mLast = mq.pop_front();
      mArgCnt++;
    end
    if (g >= 0) begin
      mq.push_back(taskIn_TDATA[g*TW + ALSB +: AW]);
      mRr = (g + 1) % NUM_CH;
    end
    @(negedge ap_clk);
  endtask

  initial begin
    ap_rst        = 1'b1;
    taskIn_TDATA  = '0;
    taskIn_TVALID = '1;
    argOut_TREADY = 1'b0;
    vData         = '0;
    vValid        = '1;
    vArgReady     = 1'b0;
    modelReset();
    repeat (2) @(negedge ap_clk);
    checkOutput("rst_tready", taskIn_TREADY, 0);
    checkOutput("rst_tvalid", argOut_TVALID, 0);
    checkOutput("rst_tdata", argOut_TDATA, 0);
    checkOutput("rst_count", fifo_count, 0);
    checkOutput("rst_argcnt", arg_count, 0);
    checkOutput("rst_var_tready", vReady, 0);
    taskIn_TVALID = '0;
    vValid        = '0;
    ap_rst        = 1'b0;

    // Single task through an empty FIFO
    taskIn_TDATA[0 +: TW] = 128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444;
    applyStimulus(4'b0001, 1'b1);
    checkOutput("single_data", argOut_TDATA, 64'hAAAA_BBBB_CCCC_DDDD);
    checkOutput("single_valid", argOut_TVALID, 1);
    applyStimulus(4'b0000, 1'b1);
    checkOutput("single_valid_drop", argOut_TVALID, 0);
    checkOutput("single_argcnt", arg_count, 1);

    // Round robin with all channels valid
    for (int i = 0; i < NUM_CH; i++) taskIn_TDATA[i*TW + ALSB +: AW] = 64'(i + 1);
    repeat (12) applyStimulus(4'b1111, 1'b1);
    repeat (2) applyStimulus(4'b0000, 1'b1);

    // Backpressure until full, then release
    repeat (6) applyStimulus(4'b0100, 1'b0);
    checkOutput("bp_full_count", fifo_count, 4);
    checkOutput("bp_tready", taskIn_TREADY, 0);
    repeat (8) applyStimulus(4'b0100, 1'b1);

    // Full FIFO with a simultaneous pop: no accept that cycle
    repeat (4) applyStimulus(4'b0100, 1'b0);
    checkOutput("fullpop_pre", fifo_count, 4);
    applyStimulus(4'b0100, 1'b1);
    checkOutput("fullpop_count", fifo_count, 3);
    applyStimulus(4'b0100, 1'b0);
    checkOutput("fullpop_refill", fifo_count, 4);

    // Randomized traffic
    repeat (300) begin
      for (int c = 0; c < NUM_CH; c++)
        taskIn_TDATA[c*TW +: TW] = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(NUM_CH'($urandom), 1'($urandom_range(0, 1)));
    end

    // Reset mid-stream with three entries buffered
    repeat (6) applyStimulus(4'b0000, 1'b1);
    repeat (3) applyStimulus(4'b0010, 1'b0);
    checkOutput("mid_pre_count", fifo_count, 3);
    taskIn_TVALID = '0;
    #2 ap_rst = 1'b1;
    #1;
    checkOutput("mid_tvalid", argOut_TVALID, 0);
    checkOutput("mid_count", fifo_count, 0);
    checkOutput("mid_argcnt", arg_count, 0);
    checkOutput("mid_tdata", argOut_TDATA, 0);
    modelReset();
    @(negedge ap_clk);
    ap_rst = 1'b0;
    taskIn_TDATA[1*TW + ALSB +: AW] = 64'h1234_5678_9ABC_DEF0;
    applyStimulus(4'b0010, 1'b1);
    checkOutput("post_rst_data", argOut_TDATA, 64'h1234_5678_9ABC_DEF0);
    checkOutput("post_rst_count", fifo_count, 1);
    applyStimulus(4'b0000, 1'b1);

    // Variant: 2 channels, 96-bit tasks, low 32 bits forwarded, 8-deep FIFO
    vValid    = 2'b11;
    vArgReady = 1'b0;
    for (int k = 0; k < 10; k++) begin
      vData = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      #1;
      checkOutput("var_tready", vReady, (k < 8) ? ((k % 2 == 0) ? 2'b01 : 2'b10) : 2'b00);
      checkOutput("var_count", vCount, (k < 8) ? k : 8);
      @(posedge ap_clk);
      if (k < 8) vq.push_back(vData[(k % 2)*96 +: 32]);
      @(negedge ap_clk);
    end
    checkOutput("var_full", vCount, 8);
    vValid    = 2'b00;
    vArgReady = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checkOutput("var_valid", vArgValid, 1);
      checkOutput("var_data", vArg, vq[i]);
      @(posedge ap_clk);
      @(negedge ap_clk);
    end
    checkOutput("var_empty", vArgValid, 0);
    checkOutput("var_argcnt", vArgCnt, 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_rr_collector.md
Name: sync_rr_collector

Overview:
- Parametrised sync PE that merges NUM_CH task streams into one argument stream.
- Round-robin arbitration selects one input channel per cycle.
- Extracts a configurable argument field from the winning task and buffers it in a DEPTH-entry FIFO.
- Full AXI-Stream valid/ready backpressure on every port; sits between the scheduler's task outputs and the argument-return network.

Parameters:
- NUM_CH, 4, number of taskIn channels (1..16).
- TASK_WIDTH, 128, task word width in bits.
- ARG_LSB, 64, bit offset of the argument field inside a task word.
- ARG_WIDTH, 64, argument width in bits; ARG_LSB+ARG_WIDTH must be <= TASK_WIDTH.
- DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
- ap_clk  in  1  clock, all logic on the rising edge.
- ap_rst  in  1  asynchronous, active-high reset.
- taskIn_TDATA  in  NUM_CH*TASK_WIDTH  channel i occupies bits [i*TASK_WIDTH +: TASK_WIDTH].
- taskIn_TVALID  in  NUM_CH  per-channel valid.
- taskIn_TREADY  out  NUM_CH  per-channel ready.
- argOut_TDATA  out  ARG_WIDTH  argument at the FIFO head.
- argOut_TVALID  out  1  FIFO not empty.
- argOut_TREADY  in  1  downstream ready.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- arg_count  out  32  total arguments emitted; wraps modulo 2^32.

Behaviour:
- Reset, asynchronous assert:
  - FIFO pointers, fifo_count, arg_count and the RR pointer go to 0.
  - argOut_TVALID=0, taskIn_TREADY=0, argOut_TDATA=0.
  - Reset mid-operation discards all buffered and in-flight data with no partial output.
  - Deassertion is taken synchronously; the first accept is possible on the first edge after deassertion.
- Arbitration, combinational:
  - grant = first channel with TVALID=1, searching from rr_ptr upward with wrap to 0.
  - taskIn_TREADY[i] = (i==grant) && any TVALID && !full.
  - At most one READY bit is high per cycle.
  - READY does not depend on argOut_TREADY: no combinational in-to-out path.
- Accept (push):
  - Occurs when TVALID[g] && TREADY[g].
  - Task bits [ARG_LSB +: ARG_WIDTH] are written to the FIFO tail on the edge.
  - rr_ptr <= (g+1) mod NUM_CH.
  - With no accept, rr_ptr holds.
- Output (pop):
  - argOut_TDATA/TVALID are driven from the registered FIFO head.
  - Pop occurs when argOut_TVALID && argOut_TREADY; arg_count increments on each pop.
  - TDATA must remain stable while TVALID=1 and TREADY=0.
- Latency: a task accepted at edge t into an empty FIFO shows argOut_TVALID=1 after edge t; minimum 1 cycle.
- Throughput: 1 argument per cycle sustained when argOut_TREADY=1.
- FIFO boundary conditions:
  - Full (count==DEPTH): all TREADY=0, even if a pop happens that same cycle. Space frees one cycle later.
  - Empty: TVALID=0; TDATA holds its last value; no pop occurs.
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- NUM_CH=1: rr_ptr fixed at 0; the block is a plain extract-and-buffer stage.

Test Plan:
- Single task: ch0 TDATA=0xAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444 at t0, argOut_TREADY=1 -> argOut_TDATA=0xAAAA_BBBB_CCCC_DDDD, TVALID=1 for exactly one cycle starting t0+1; arg_count=1.
- Round robin: all 4 channels valid continuously, channel i data upper half = i+1, TREADY=1 -> output sequence 1,2,3,4,1,2,...; each TREADY pulses once every 4 cycles.
- Backpressure: argOut_TREADY=0, ch2 always valid -> 4 accepts, fifo_count=4, all TREADY=0; TDATA stable. Raise argOut_TREADY -> 4 pops in order, then accepts resume at 1 per cycle.
- Full with simultaneous pop: count=4, argOut_TREADY=1 for one cycle -> no accept that cycle; count=3; accept on the next cycle restores count=4.
- Reset mid-stream: assert ap_rst asynchronously between edges with count=3 -> TVALID, fifo_count and arg_count drop to 0 immediately; after release the first new task appears at t+1 with no stale data.
- Param variant: NUM_CH=2, TASK_WIDTH=96, ARG_LSB=0, ARG_WIDTH=32, DEPTH=8 -> low 32 bits forwarded; 8 accepts before stall.
